dm_bytelane_sweep: RTL

//  Parametrised MIPS data memory for the MEM stage; next generation of the word-only DM.

---
 rtl/dm_pkg.sv | 14 +
 rtl/dm_lane_unit.sv | 45 ++++
 rtl/dm_bytelane_sweep.sv | 121 ++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared encodings for the byte-lane data memory: access modes, sweep FSM states
// and the store trace format.
package dm_pkg;

  localparam logic [1:0] MODE_WORD = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_BYTE = 2'b10;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  localparam string TRACE_FMT = "%d@%h: *%h <= %h";

endpackage

// File: rtl/dm_lane_unit.sv
// Combinational lane logic: store byte enables and replicated data, load extraction
// with sign/zero extension, and alignment check.
module dm_lane_unit
  import dm_pkg::*;
(
  input  logic [1:0]  mode_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wd_i,
  input  logic [31:0] rdata_i,
  input  logic        sext_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{lane_i, 3'b000} +: 8];
  assign half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    be_o       = 4'b1111;
    wdata_o    = wd_i;
    ldata_o    = rdata_i;
    misalign_o = (lane_i != 2'b00);
    case (mode_i)
      MODE_HALF: begin
        be_o       = 4'b0011 << lane_i;
        wdata_o    = {2{wd_i[15:0]}};
        ldata_o    = sext_i ? {{16{half_sel[15]}}, half_sel} : {16'h0000, half_sel};
        misalign_o = lane_i[0];
      end
      MODE_BYTE: begin
        be_o       = 4'b0001 << lane_i;
        wdata_o    = {4{wd_i[7:0]}};
        ldata_o    = sext_i ? {{24{byte_sel[7]}}, byte_sel} : {24'h000000, byte_sel};
        misalign_o = 1'b0;
      end
      default: ;  // word and the reserved encoding behave as word
    endcase
  end

endmodule

// File: rtl/dm_bytelane_sweep.sv
// MEM-stage data memory with byte/half/word access, range and alignment checks,
// and a multi-cycle zeroing sweep that runs after reset and on flush.
module dm_bytelane_sweep
  import dm_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          CLR_WORDS  = 1,
  parameter int          TRACE      = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        flush,
  input  logic        we,
  input  logic [1:0]  mode,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic [31:0] pc,
  output logic [31:0] dr,
  output logic        busy,
  output logic        misalign,
  output logic        oob
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_STEP = DEPTH_LOG2'(CLR_WORDS);
  localparam logic [DEPTH_LOG2-1:0] PTR_LAST = DEPTH_LOG2'(DEPTH - CLR_WORDS);
  localparam logic [32:0]           LIMIT    = 33'(1) << (DEPTH_LOG2 + 2);

  logic [31:0]           mem_q [DEPTH];
  logic [0:0]            state_q, state_d;
  logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;

  logic [31:0]           off;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           rdata;
  logic [31:0]           wdata;
  logic [31:0]           ldata;
  logic [31:0]           merged;
  logic [3:0]            be;
  logic                  wr_en;

  // Offsets below BASE_ADDR wrap to large values and fall out of range.
  assign off      = addr - BASE_ADDR;
  assign idx      = off[DEPTH_LOG2+1:2];
  assign oob      = ({1'b0, off} >= LIMIT);
  assign busy     = (state_q == ST_SWEEP);
  assign rdata    = mem_q[idx];
  assign wr_en    = we & ~busy & ~flush & ~misalign & ~oob;
  assign dr       = (busy | oob) ? 32'h0000_0000 : ldata;

  dm_lane_unit u_lane (
    .mode_i     (mode),
    .lane_i     (addr[1:0]),
    .wd_i       (wd),
    .rdata_i    (rdata),
    .sext_i     (sext),
    .be_o       (be),
    .wdata_o    (wdata),
    .ldata_o    (ldata),
    .misalign_o (misalign)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign merged[gi*8 +: 8] = be[gi] ? wdata[gi*8 +: 8] : rdata[gi*8 +: 8];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_SWEEP: begin
        if (flush) begin
          ptr_d = '0;
        end else if (ptr_q == PTR_LAST) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + PTR_STEP;
        end
      end
      default: begin
        if (flush) begin
          state_d = ST_SWEEP;
          ptr_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_SWEEP;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // The array has no reset; the sweep is the only way contents get cleared.
  always_ff @(posedge clk) begin
    if (state_q == ST_SWEEP) begin
      for (int k = 0; k < CLR_WORDS; k++) begin
        mem_q[ptr_q + DEPTH_LOG2'(k)] <= '0;
      end
    end else if (wr_en) begin
      mem_q[idx] <= merged;
    end
  end

  if (TRACE != 0) begin : g_trace
    always @(posedge clk) begin
      if (wr_en) begin
        $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, merged);
      end
    end
  end

endmodule
